// File: rtl/axis_fifo_if.sv
// rtl/axis_fifo_if.sv - AXI-Stream style interface bundle with master/slave modports
interface ifc_axis #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_fifo.sv
// rtl/axis_fifo.sv - AXI-Stream FIFO with optional sidebands and store-and-forward frame mode
module axis_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = 0,
  parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
  parameter int LAST_ENABLE = 0,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 0,
  parameter int USER_WIDTH  = 1,
  parameter int DEPTH       = 16,
  parameter int FRAME_FIFO  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  ifc_axis.slave                 s_axis_ifc,
  ifc_axis.master                m_axis_ifc,
  output logic [$clog2(DEPTH):0] status_count,
  output logic [$clog2(DEPTH):0] status_frames,
  output logic                   status_full,
  output logic                   status_empty
);
  localparam int AW       = $clog2(DEPTH);
  localparam int PW       = AW + 1;
  localparam int KEEP_OFF = DATA_WIDTH;
  localparam int LAST_OFF = KEEP_OFF + ((KEEP_ENABLE != 0) ? KEEP_WIDTH : 0);
  localparam int ID_OFF   = LAST_OFF + ((LAST_ENABLE != 0) ? 1 : 0);
  localparam int DEST_OFF = ID_OFF + ((ID_ENABLE != 0) ? ID_WIDTH : 0);
  localparam int USER_OFF = DEST_OFF + ((DEST_ENABLE != 0) ? DEST_WIDTH : 0);
  localparam int WW       = USER_OFF + ((USER_ENABLE != 0) ? USER_WIDTH : 0);

  logic [WW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_frames;

  logic [PW-1:0] w_count;
  logic [WW-1:0] w_wr_word;
  logic [WW-1:0] w_rd_word;
  logic          w_full;
  logic          w_empty;
  logic          w_write;
  logic          w_read;
  logic          w_wr_last;
  logic          w_rd_last;
  logic          w_m_valid;
  logic          w_unused;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == PW'(DEPTH));
  assign w_empty = (w_count == '0);

  assign s_axis_ifc.tready = !w_full;
  assign w_write = s_axis_ifc.tvalid && !w_full;
  assign w_read  = w_m_valid && m_axis_ifc.tready;

  // Frame mode waits for a complete frame; a full FIFO lets an oversize frame cut through.
  if (FRAME_FIFO != 0) begin : g_frame
    assign w_m_valid = !w_empty && ((r_frames != '0) || w_full);
  end else begin : g_stream
    assign w_m_valid = !w_empty;
  end
  assign m_axis_ifc.tvalid = w_m_valid;

  // Asynchronous read of the head slot: the slot is never rewritten while it is valid.
  assign w_rd_word = r_mem[r_rd_ptr[AW-1:0]];
  assign w_wr_word[DATA_WIDTH-1:0] = s_axis_ifc.tdata;
  assign m_axis_ifc.tdata = w_rd_word[DATA_WIDTH-1:0];

  if (KEEP_ENABLE != 0) begin : g_keep
    assign w_wr_word[KEEP_OFF +: KEEP_WIDTH] = s_axis_ifc.tkeep;
    assign m_axis_ifc.tkeep = w_rd_word[KEEP_OFF +: KEEP_WIDTH];
  end else begin : g_no_keep
    assign m_axis_ifc.tkeep = '1;
  end

  if (LAST_ENABLE != 0) begin : g_last
    assign w_wr_word[LAST_OFF] = s_axis_ifc.tlast;
    assign w_wr_last = s_axis_ifc.tlast;
    assign w_rd_last = w_rd_word[LAST_OFF];
  end else begin : g_no_last
    assign w_wr_last = 1'b0;
    assign w_rd_last = 1'b0;
  end
  assign m_axis_ifc.tlast = w_rd_last;

  if (ID_ENABLE != 0) begin : g_id
    assign w_wr_word[ID_OFF +: ID_WIDTH] = s_axis_ifc.tid;
    assign m_axis_ifc.tid = w_rd_word[ID_OFF +: ID_WIDTH];
  end else begin : g_no_id
    assign m_axis_ifc.tid = '0;
  end

  if (DEST_ENABLE != 0) begin : g_dest
    assign w_wr_word[DEST_OFF +: DEST_WIDTH] = s_axis_ifc.tdest;
    assign m_axis_ifc.tdest = w_rd_word[DEST_OFF +: DEST_WIDTH];
  end else begin : g_no_dest
    assign m_axis_ifc.tdest = '0;
  end

  if (USER_ENABLE != 0) begin : g_user
    assign w_wr_word[USER_OFF +: USER_WIDTH] = s_axis_ifc.tuser;
    assign m_axis_ifc.tuser = w_rd_word[USER_OFF +: USER_WIDTH];
  end else begin : g_no_user
    assign m_axis_ifc.tuser = '0;
  end

  assign w_unused = ^{s_axis_ifc.tkeep, s_axis_ifc.tlast, s_axis_ifc.tid,
                      s_axis_ifc.tdest, s_axis_ifc.tuser};

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_wr_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_frames <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_read) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_write && w_wr_last, w_read && w_rd_last})
        2'b10:   r_frames <= r_frames + PW'(1);
        2'b01:   r_frames <= r_frames - PW'(1);
        default: r_frames <= r_frames;
      endcase
    end
  end

  assign status_count  = w_count;
  assign status_frames = r_frames;
  assign status_full   = w_full;
  assign status_empty  = w_empty;
endmodule

// File: tb/tb_axis_fifo.sv
// tb/tb_axis_fifo.sv - directed vector bench for axis_fifo in stream, frame and sideband configurations
module tb_axis_fifo;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifc_axis #(.DATA_WIDTH(8)) a_s ();
  ifc_axis #(.DATA_WIDTH(8)) a_m ();
  ifc_axis #(.DATA_WIDTH(8)) b_s ();
  ifc_axis #(.DATA_WIDTH(8)) b_m ();
  ifc_axis #(.DATA_WIDTH(8)) c_s ();
  ifc_axis #(.DATA_WIDTH(8)) c_m ();

  logic [2:0] a_cnt, a_frm, b_cnt, b_frm;
  logic [4:0] c_cnt, c_frm;
  logic       a_full, a_empty, b_full, b_empty, c_full, c_empty;

  axis_fifo #(.DEPTH(4), .KEEP_ENABLE(1), .LAST_ENABLE(1), .ID_ENABLE(1)) dut_a (
    .clk(clk), .rst(rst), .s_axis_ifc(a_s), .m_axis_ifc(a_m),
    .status_count(a_cnt), .status_frames(a_frm), .status_full(a_full), .status_empty(a_empty));

  axis_fifo #(.DEPTH(4), .LAST_ENABLE(1), .FRAME_FIFO(1)) dut_b (
    .clk(clk), .rst(rst), .s_axis_ifc(b_s), .m_axis_ifc(b_m),
    .status_count(b_cnt), .status_frames(b_frm), .status_full(b_full), .status_empty(b_empty));

  axis_fifo dut_c (
    .clk(clk), .rst(rst), .s_axis_ifc(c_s), .m_axis_ifc(c_m),
    .status_count(c_cnt), .status_frames(c_frm), .status_full(c_full), .status_empty(c_empty));

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       ev;
    logic [7:0] ed;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
  } vec_t;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t v(logic sv, logic [7:0] sd, logic mr, logic ev, logic [7:0] ed,
                             logic [2:0] cnt, logic full, logic empty);
    vec_t r;
    r.sv = sv; r.sd = sd; r.mr = mr; r.ev = ev; r.ed = ed;
    r.cnt = cnt; r.full = full; r.empty = empty;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [16];
    logic [7:0] q [$];
    int         src, nout, model_cnt;
    logic       seen_full;

    vecs[0]  = v(H, 8'h11, L, L, 8'h00, 3'd0, L, H);
    vecs[1]  = v(H, 8'h22, L, H, 8'h11, 3'd1, L, L);
    vecs[2]  = v(H, 8'h33, L, H, 8'h11, 3'd2, L, L);
    vecs[3]  = v(L, 8'h00, L, H, 8'h11, 3'd3, L, L);
    vecs[4]  = v(L, 8'h00, H, H, 8'h11, 3'd3, L, L);
    vecs[5]  = v(L, 8'h00, H, H, 8'h22, 3'd2, L, L);
    vecs[6]  = v(L, 8'h00, H, H, 8'h33, 3'd1, L, L);
    vecs[7]  = v(L, 8'h00, L, L, 8'h00, 3'd0, L, H);
    vecs[8]  = v(H, 8'h41, L, L, 8'h00, 3'd0, L, H);
    vecs[9]  = v(H, 8'h42, L, H, 8'h41, 3'd1, L, L);
    vecs[10] = v(H, 8'h43, L, H, 8'h41, 3'd2, L, L);
    vecs[11] = v(H, 8'h44, L, H, 8'h41, 3'd3, L, L);
    vecs[12] = v(H, 8'h45, L, H, 8'h41, 3'd4, H, L);
    vecs[13] = v(H, 8'h45, H, H, 8'h41, 3'd4, H, L);
    vecs[14] = v(H, 8'h45, L, H, 8'h42, 3'd3, L, L);
    vecs[15] = v(L, 8'h00, L, H, 8'h42, 3'd4, H, L);

    rst = 1'b1;
    a_s.tvalid = 1'b0; a_s.tdata = '0; a_s.tkeep = 1'b1; a_s.tlast = 1'b0;
    a_s.tid = '0; a_s.tdest = '0; a_s.tuser = '0; a_m.tready = 1'b0;
    b_s.tvalid = 1'b0; b_s.tdata = '0; b_s.tkeep = 1'b1; b_s.tlast = 1'b0;
    b_s.tid = '0; b_s.tdest = '0; b_s.tuser = '0; b_m.tready = 1'b0;
    c_s.tvalid = 1'b0; c_s.tdata = '0; c_s.tkeep = 1'b1; c_s.tlast = 1'b0;
    c_s.tid = '0; c_s.tdest = '0; c_s.tuser = '0; c_m.tready = 1'b0;

    #12;
    chk("rst.a_m_valid", 32'(a_m.tvalid), 32'(0));
    chk("rst.a_s_ready", 32'(a_s.tready), 32'(1));
    chk("rst.a_count",   32'(a_cnt), 32'(0));
    chk("rst.a_empty",   32'(a_empty), 32'(1));
    chk("rst.a_full",    32'(a_full), 32'(0));
    chk("rst.b_frames",  32'(b_frm), 32'(0));
    chk("rst.b_m_valid", 32'(b_m.tvalid), 32'(0));
    chk("rst.c_empty",   32'(c_empty), 32'(1));
    chk("rst.c_count",   32'(c_cnt), 32'(0));
    #1 rst = 1'b0;
    tick();

    // Basic flow, fill, full/read interplay on the stream FIFO
    for (int i = 0; i < 16; i++) begin
      a_s.tvalid = vecs[i].sv;
      a_s.tdata  = vecs[i].sd;
      a_m.tready = vecs[i].mr;
      #1;
      chk($sformatf("vec%0d.m_valid", i), 32'(a_m.tvalid), 32'(vecs[i].ev));
      if (vecs[i].ev) chk($sformatf("vec%0d.m_data", i), 32'(a_m.tdata), 32'(vecs[i].ed));
      chk($sformatf("vec%0d.count", i), 32'(a_cnt), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d.full", i), 32'(a_full), 32'(vecs[i].full));
      chk($sformatf("vec%0d.empty", i), 32'(a_empty), 32'(vecs[i].empty));
      chk($sformatf("vec%0d.s_ready", i), 32'(a_s.tready), 32'(!vecs[i].full));
      tick();
    end

    // Stream 10 beats through the full FIFO with the sink always ready
    q = '{8'h42, 8'h43, 8'h44, 8'h45};
    src = 0; nout = 0;
    a_m.tready = 1'b1;
    for (int cyc = 0; cyc < 60 && (src < 10 || q.size() > 0); cyc++) begin
      a_s.tvalid = (src < 10);
      a_s.tdata  = 8'(32'h60 + src);
      #1;
      model_cnt = q.size();
      chk("stream.s_ready", 32'(a_s.tready), 32'(model_cnt < 4));
      chk("stream.m_valid", 32'(a_m.tvalid), 32'(model_cnt > 0));
      if (model_cnt > 0) begin
        chk($sformatf("stream.data%0d", nout), 32'(a_m.tdata), 32'(q[0]));
        void'(q.pop_front());
        nout++;
      end
      if (src < 10 && model_cnt < 4) begin
        q.push_back(8'(32'h60 + src));
        src++;
      end
      tick();
    end
    chk("stream.total_out", 32'(nout), 32'(14));
    a_s.tvalid = 1'b0;
    a_m.tready = 1'b0;
    #1;
    chk("stream.empty", 32'(a_empty), 32'(1));
    tick();

    // Sidebands carried when enabled
    a_s.tvalid = 1'b1; a_s.tdata = 8'hA1; a_s.tkeep = 1'b1; a_s.tid = 8'h5A; a_s.tlast = 1'b1;
    tick();
    a_s.tdata = 8'hA2; a_s.tkeep = 1'b0; a_s.tid = 8'h33; a_s.tlast = 1'b0;
    tick();
    a_s.tvalid = 1'b0;
    #1;
    chk("sb.a_data0", 32'(a_m.tdata), 32'h0A1);
    chk("sb.a_keep0", 32'(a_m.tkeep), 32'(1));
    chk("sb.a_id0",   32'(a_m.tid), 32'h05A);
    chk("sb.a_last0", 32'(a_m.tlast), 32'(1));
    chk("sb.a_frames", 32'(a_frm), 32'(1));
    a_m.tready = 1'b1;
    tick();
    chk("sb.a_data1", 32'(a_m.tdata), 32'h0A2);
    chk("sb.a_keep1", 32'(a_m.tkeep), 32'(0));
    chk("sb.a_id1",   32'(a_m.tid), 32'h033);
    chk("sb.a_last1", 32'(a_m.tlast), 32'(0));
    chk("sb.a_frames_after", 32'(a_frm), 32'(0));
    tick();
    a_m.tready = 1'b0;

    // Sidebands forced to constants when disabled
    c_s.tvalid = 1'b1; c_s.tdata = 8'hC3; c_s.tkeep = 1'b0; c_s.tid = 8'h5A;
    c_s.tlast = 1'b1; c_s.tdest = 8'h07; c_s.tuser = 1'b1;
    tick();
    c_s.tvalid = 1'b0;
    #1;
    chk("sb.c_valid", 32'(c_m.tvalid), 32'(1));
    chk("sb.c_data",  32'(c_m.tdata), 32'h0C3);
    chk("sb.c_keep",  32'(c_m.tkeep), 32'(1));
    chk("sb.c_id",    32'(c_m.tid), 32'(0));
    chk("sb.c_last",  32'(c_m.tlast), 32'(0));
    chk("sb.c_dest",  32'(c_m.tdest), 32'(0));
    chk("sb.c_user",  32'(c_m.tuser), 32'(0));
    chk("sb.c_frames", 32'(c_frm), 32'(0));
    chk("sb.c_count", 32'(c_cnt), 32'(1));

    // Store-and-forward: no output until the frame's last beat is stored
    b_m.tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b_s.tvalid = 1'b1;
      b_s.tdata  = 8'(32'hB0 + i);
      b_s.tlast  = (i == 2);
      #1;
      chk($sformatf("saf.hold%0d.m_valid", i), 32'(b_m.tvalid), 32'(0));
      chk($sformatf("saf.hold%0d.frames", i), 32'(b_frm), 32'(0));
      tick();
    end
    b_s.tvalid = 1'b0; b_s.tlast = 1'b0;
    #1;
    chk("saf.m_valid", 32'(b_m.tvalid), 32'(1));
    chk("saf.frames",  32'(b_frm), 32'(1));
    chk("saf.count",   32'(b_cnt), 32'(3));
    chk("saf.data0",   32'(b_m.tdata), 32'h0B0);
    tick();
    chk("saf.data1", 32'(b_m.tdata), 32'h0B1);
    chk("saf.last1", 32'(b_m.tlast), 32'(0));
    tick();
    chk("saf.data2", 32'(b_m.tdata), 32'h0B2);
    chk("saf.last2", 32'(b_m.tlast), 32'(1));
    chk("saf.valid2", 32'(b_m.tvalid), 32'(1));
    tick();
    chk("saf.frames_drained", 32'(b_frm), 32'(0));
    chk("saf.empty", 32'(b_empty), 32'(1));
    chk("saf.m_valid_drained", 32'(b_m.tvalid), 32'(0));

    // Oversize frame must cut through once the FIFO fills
    src = 0; nout = 0; seen_full = 1'b0;
    for (int cyc = 0; cyc < 40 && nout < 6; cyc++) begin
      b_s.tvalid = (src < 6);
      b_s.tdata  = 8'(32'hD1 + src);
      b_s.tlast  = (src == 5);
      #1;
      if (b_full && !seen_full) begin
        seen_full = 1'b1;
        chk("big.full_valid",  32'(b_m.tvalid), 32'(1));
        chk("big.full_frames", 32'(b_frm), 32'(0));
      end else if (!seen_full) begin
        chk($sformatf("big.prefull%0d.m_valid", cyc), 32'(b_m.tvalid), 32'(0));
      end
      if (b_m.tvalid) begin
        chk($sformatf("big.data%0d", nout), 32'(b_m.tdata), 32'hD1 + 32'(nout));
        chk($sformatf("big.last%0d", nout), 32'(b_m.tlast), 32'(nout == 5));
        nout++;
      end
      if (b_s.tvalid && b_s.tready) src++;
      tick();
    end
    chk("big.delivered", 32'(nout), 32'(6));
    chk("big.seen_full", 32'(seen_full), 32'(1));
    b_s.tvalid = 1'b0; b_s.tlast = 1'b0;
    #1;
    chk("big.empty", 32'(b_empty), 32'(1));
    tick();

    // Reset mid-operation: one full frame plus half of the next
    b_m.tready = 1'b0;
    b_s.tvalid = 1'b1; b_s.tdata = 8'h91; b_s.tlast = 1'b0;
    tick();
    b_s.tdata = 8'h92; b_s.tlast = 1'b1;
    tick();
    b_s.tdata = 8'h93; b_s.tlast = 1'b0;
    tick();
    b_s.tvalid = 1'b0;
    #1;
    chk("mid.pre_count",  32'(b_cnt), 32'(3));
    chk("mid.pre_frames", 32'(b_frm), 32'(1));
    chk("mid.pre_valid",  32'(b_m.tvalid), 32'(1));
    #1 rst = 1'b1;
    #1;
    chk("mid.rst_valid",  32'(b_m.tvalid), 32'(0));
    chk("mid.rst_count",  32'(b_cnt), 32'(0));
    chk("mid.rst_empty",  32'(b_empty), 32'(1));
    chk("mid.rst_full",   32'(b_full), 32'(0));
    chk("mid.rst_frames", 32'(b_frm), 32'(0));
    chk("mid.rst_s_ready", 32'(b_s.tready), 32'(1));
    b_s.tvalid = 1'b1; b_s.tdata = 8'h77; b_s.tlast = 1'b1;
    #2 rst = 1'b0;
    tick();
    b_s.tvalid = 1'b0; b_s.tlast = 1'b0;
    #1;
    chk("mid.post_count",  32'(b_cnt), 32'(1));
    chk("mid.post_frames", 32'(b_frm), 32'(1));
    chk("mid.post_valid",  32'(b_m.tvalid), 32'(1));
    chk("mid.post_data",   32'(b_m.tdata), 32'h077);
    chk("mid.post_last",   32'(b_m.tlast), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_fifo.md
AXIS_FIFO -- requirements
Module: axis_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, tdata width in bits.
REQ-002 SHALL have parameters KEEP_ENABLE 0, KEEP_WIDTH (DATA_WIDTH+7)/8, LAST_ENABLE 0, ID_ENABLE 0, ID_WIDTH 8, DEST_ENABLE 0, DEST_WIDTH 8, USER_ENABLE 0, USER_WIDTH 1, each enabling or sizing the matching sideband field.
REQ-003 SHALL have parameter DEPTH, default 16, entry count; must be a power of 2 and at least 2.
REQ-004 SHALL have parameter FRAME_FIFO, default 0; 1 selects store-and-forward mode and requires LAST_ENABLE=1.
REQ-005 SHALL have port clk, input, 1 bit, the single clock.
REQ-006 SHALL have port rst, input, 1 bit; asynchronous, active-high reset.
REQ-007 SHALL have port s_axis_ifc, ifc_axis.slave, the input stream.
REQ-008 SHALL have port m_axis_ifc, ifc_axis.master, the output stream.
REQ-009 SHALL have port status_count, output, $clog2(DEPTH)+1 bits, the number of stored entries.
REQ-010 SHALL have port status_frames, output, $clog2(DEPTH)+1 bits, the number of complete stored frames; it reads 0 when LAST_ENABLE=0.
REQ-011 SHALL have ports status_full and status_empty, outputs, 1 bit each.

Function
REQ-012 SHALL store each beat as one packed word: data at [DATA_WIDTH-1:0], then keep, last, id, dest and user in that order, each field present only when enabled.
REQ-013 SHALL drive disabled output sideband fields to constants: tkeep all ones; tlast, tid, tdest and tuser all zeros.
REQ-014 SHALL use the storage array plus write and read pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty on equal indices.
REQ-015 SHALL define a write as s_axis tvalid&&tready and a read as m_axis tvalid&&tready, both sampled at the rising clk edge.
REQ-016 SHALL drive s_axis tready = !status_full (combinational from registered state), with no dependence on m_axis tready.
REQ-017 SHALL advance the write pointer by 1 on a write and the read pointer by 1 on a read; pointers wrap modulo 2*DEPTH.
REQ-018 SHALL compute status_count = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1).
REQ-019 SHALL assert status_full when count==DEPTH and status_empty when count==0.
REQ-020 SHALL make written data visible on m_axis one cycle after the write edge at the earliest, with no combinational input-to-output bypass.
REQ-021 SHALL, when FRAME_FIFO=0, drive m_axis tvalid = !status_empty.
REQ-022 SHALL, when FRAME_FIFO=1, drive m_axis tvalid = !status_empty && (status_frames!=0 || status_full).
REQ-023 SHALL treat the status_full term as a cut-through escape, so that a frame longer than DEPTH drains instead of deadlocking.
REQ-024 SHALL increment status_frames on a write carrying tlast=1 and decrement it on a read carrying tlast=1; simultaneous increment and decrement leave it unchanged.
REQ-025 SHALL hold m_axis data stable while m_axis tvalid=1 and tready=0.
REQ-026 SHALL, when full, perform only a read on a cycle with both sides active, and accept a write on the next cycle.
REQ-027 SHALL, when empty, perform only a write on a cycle with both sides active.
REQ-028 SHALL update both pointers in the same cycle on a simultaneous write and read when neither full nor empty, leaving the count unchanged.

Reset
REQ-029 SHALL, on rst assertion at any time, asynchronously clear wr_ptr, rd_ptr and the frame counter.
REQ-030 SHALL hold the following outputs during reset: m_axis tvalid=0, s_axis tready=1, status_count=0, status_frames=0, status_empty=1, status_full=0.
REQ-031 SHALL not reset the storage array, and SHALL discard any stored or partially received frame on reset.
REQ-032 SHALL release reset on the first rising clk edge after rst deasserts, and accept a write on that edge.

Verification
REQ-033 SHALL verify basic flow: DEPTH=4, FRAME_FIFO=0, write 0x11,0x22,0x33 with m tready=0 -> count=3, m tvalid=1, m tdata=0x11; raise tready -> 0x11,0x22,0x33 out in order on consecutive cycles, then empty=1.
REQ-034 SHALL verify fill and wrap: DEPTH=4, write 4 beats -> full=1, s tready=0; read 1 while s tvalid=1 -> next edge accepts the 5th beat; stream 10 beats with tready=1 -> all 10 out in order with none lost or duplicated.
REQ-035 SHALL verify store-and-forward: FRAME_FIFO=1, LAST_ENABLE=1, write a 3-beat frame with tlast on beat 3 -> m tvalid=0 until the cycle after beat 3, then status_frames=1; after draining, status_frames=0.
REQ-036 SHALL verify oversize frame: FRAME_FIFO=1, DEPTH=4, 6-beat frame -> once full, m tvalid=1 with frames=0, and all 6 beats are delivered with tlast on beat 6.
REQ-037 SHALL verify sidebands: KEEP_ENABLE=1, ID_ENABLE=1, write tkeep=0x1, tid=0x5A -> the same values appear on output; with them disabled -> tkeep=all ones, tid=0.
REQ-038 SHALL verify reset mid-operation: 2 entries stored plus a half frame, assert rst between clk edges -> immediately m tvalid=0, count=0, empty=1; after release, a new write is output correctly.
